// File: rtl/instr_fetch_mem_pkg.sv
// Shared types and constants for the TinyChip instruction memory.
// The optional per-word parity feature is selected with IMEM_PARITY_EN.
package imem_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } imem_state_e;

    // Widest word the parity helper accepts; narrower words are zero-extended.
    localparam int PARITY_MAX_W = 64;

    // Default NOP and the two-word boot image present after elaboration.
    localparam logic [8:0] IMEM_NOP_DEFAULT = 9'h000;
    localparam logic [8:0] IMEM_IMG_WORD0   = 9'h10F;
    localparam logic [8:0] IMEM_IMG_WORD1   = 9'h1AB;

    // Even parity bit: makes the total number of ones (word + bit) even.
    // Zero-extension does not change the result.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/instr_fetch_mem_array.sv
// Instruction storage: one synchronous write port and one registered read
// port. Contents start from the elaboration-time image and survive reset.
module imem_array
    import imem_pkg::*;
#(
    parameter int               W      = 9,
    parameter int               DEPTH  = 256,
    parameter int               ADDR_W = $clog2(DEPTH),
    parameter logic [W-1:0]     INIT0  = '0,
    parameter logic [W-1:0]     INIT1  = '0,
    parameter logic [W-1:0]     FILL   = '0
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [W-1:0]      i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [W-1:0]      o_rdata
);

    logic [W-1:0] r_mem [DEPTH] = '{0: INIT0, 1: INIT1, default: FILL};
    logic [W-1:0] r_rdata;

    // Write the addressed word and capture the read word; callers only
    // present in-range addresses.
    // NOTE: the array and read register have no reset on purpose -- a reset
    // would force the storage into flops and would wipe a loaded program.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory for the TinyChip fetch stage: registered
// one-per-cycle fetch with stall hold, plus a valid/ready program loader.
// Define IMEM_PARITY_EN to store and check an even-parity bit per word.
module instr_fetch_mem
    import imem_pkg::*;
#(
    parameter int                   INSTR_W  = 9,
    parameter int                   DEPTH    = 256,
    parameter int                   ADDR_W   = $clog2(DEPTH),
    parameter logic [INSTR_W-1:0]   NOP_WORD = INSTR_W'(IMEM_NOP_DEFAULT)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_fetch_req,
    input  logic [ADDR_W-1:0]  i_fetch_addr,
    input  logic               i_stall,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_instr_valid,
    output logic               o_addr_err,
    input  logic               i_load_start,
    input  logic               i_load_valid,
    input  logic [INSTR_W-1:0] i_load_data,
    input  logic               i_load_last,
    output logic               o_load_ready,
    output logic               o_load_done,
    output logic               o_parity_err
);

`ifdef IMEM_PARITY_EN
    localparam int MEM_W = INSTR_W + 1;
    localparam logic [INSTR_W-1:0] L_W0 = INSTR_W'(IMEM_IMG_WORD0);
    localparam logic [INSTR_W-1:0] L_W1 = INSTR_W'(IMEM_IMG_WORD1);
    localparam logic [MEM_W-1:0] L_INIT0 = {even_parity(PARITY_MAX_W'(L_W0)), L_W0};
    localparam logic [MEM_W-1:0] L_INIT1 = {even_parity(PARITY_MAX_W'(L_W1)), L_W1};
    localparam logic [MEM_W-1:0] L_FILL  = {even_parity(PARITY_MAX_W'(NOP_WORD)), NOP_WORD};
`else
    localparam int MEM_W = INSTR_W;
    localparam logic [MEM_W-1:0] L_INIT0 = INSTR_W'(IMEM_IMG_WORD0);
    localparam logic [MEM_W-1:0] L_INIT1 = INSTR_W'(IMEM_IMG_WORD1);
    localparam logic [MEM_W-1:0] L_FILL  = NOP_WORD;
`endif

    imem_state_e        r_state;
    logic [ADDR_W-1:0]  r_ptr;
    logic               r_load_ready;
    logic               r_load_done;
    logic               r_instr_valid;
    logic               r_addr_err;
    logic               r_nop;          // instr shows NOP_WORD instead of read data

    logic               w_oob;
    logic               w_rd_en;
    logic               w_wr_en;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic               w_last_word;
    logic [MEM_W-1:0]   w_wdata;
    logic [MEM_W-1:0]   w_rdata;

    assign w_oob       = (32'(i_fetch_addr) >= DEPTH);
    assign w_rd_en     = (r_state == RUN) && !i_load_start && !i_stall
                         && i_fetch_req && !w_oob;
    assign w_wr_en     = (r_state == LOAD) && i_load_valid;
    // A restart in LOAD sends the same-cycle word to address 0.
    assign w_wr_addr   = i_load_start ? '0 : r_ptr;
    assign w_last_word = i_load_last || (32'(w_wr_addr) == DEPTH - 1);

    imem_array #(
        .W      (MEM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .INIT0  (L_INIT0),
        .INIT1  (L_INIT1),
        .FILL   (L_FILL)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_wr_en),
        .i_waddr (w_wr_addr),
        .i_wdata (w_wdata),
        .i_re    (w_rd_en),
        .i_raddr (i_fetch_addr),
        .o_rdata (w_rdata)
    );

    // RUN/LOAD controller: load pointer, handshake outputs and fetch status.
    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= RUN;
            r_ptr         <= '0;
            r_load_ready  <= 1'b0;
            r_load_done   <= 1'b0;
            r_instr_valid <= 1'b0;
            r_addr_err    <= 1'b0;
            r_nop         <= 1'b1;
        end else begin
            r_load_done <= 1'b0;
            if (r_state == LOAD) begin
                if (w_wr_en && w_last_word) begin
                    r_state      <= RUN;
                    r_ptr        <= '0;
                    r_load_ready <= 1'b0;
                    r_load_done  <= 1'b1;
                end else if (w_wr_en) begin
                    r_ptr <= w_wr_addr + ADDR_W'(1);
                end else if (i_load_start) begin
                    r_ptr <= '0;
                end
            end else if (i_load_start) begin
                r_state       <= LOAD;
                r_ptr         <= '0;
                r_load_ready  <= 1'b1;
                r_instr_valid <= 1'b0;
                r_addr_err    <= 1'b0;
                r_nop         <= 1'b1;
            end else if (!i_stall) begin
                r_instr_valid <= i_fetch_req;
                r_addr_err    <= i_fetch_req && w_oob;
                if (i_fetch_req) begin
                    r_nop <= w_oob;
                end
            end
        end
    end

`ifdef IMEM_PARITY_EN
    assign w_wdata      = {even_parity(PARITY_MAX_W'(i_load_data)), i_load_data};
    assign o_instr      = r_nop ? NOP_WORD : w_rdata[INSTR_W-1:0];
    assign o_parity_err = r_instr_valid && !r_nop && (^w_rdata);
`else
    assign w_wdata      = i_load_data;
    assign o_instr      = r_nop ? NOP_WORD : w_rdata;
    assign o_parity_err = 1'b0;
`endif

    assign o_instr_valid = r_instr_valid;
    assign o_addr_err    = r_addr_err;
    assign o_load_ready  = r_load_ready;
    assign o_load_done   = r_load_done;

endmodule

// File: doc/instr_fetch_mem.md
# instr_fetch_mem

Parametrised, loadable instruction memory for the TinyChip core. Holds the program in a DEPTH x INSTR_W array, serves one registered fetch per cycle to the fetch stage with stall support, and accepts a sequential program image over a valid/ready load port so the program no longer has to be fixed at elaboration. It sits between the PC register and the decoder.

## Interface
- INSTR_W, 9, instruction word width in bits.
- DEPTH, 256, number of instruction words; need not be a power of two.
- ADDR_W, $clog2(DEPTH), fetch address width.
- NOP_WORD, '0, word driven on reset, on out-of-range fetches, and in LOAD state.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch request for fetch_addr this cycle.
- fetch_addr  in  ADDR_W  word address from the PC.
- stall  in  1  hold instr/instr_valid; has priority over fetch_req.
- instr  out  INSTR_W  fetched instruction, registered.
- instr_valid  out  1  instr holds a fresh fetch result.
- addr_err  out  1  one-cycle pulse: the fetch now on instr had fetch_addr >= DEPTH.
- load_start  in  1  enter LOAD; the write pointer restarts at 0.
- load_valid  in  1  load_data is valid.
- load_data  in  INSTR_W  program word.
- load_last  in  1  qualifies load_valid; this is the final word.
- load_ready  out  1  high in LOAD only.
- load_done  out  1  one-cycle pulse when LOAD finishes.
- parity_err  out  1  parity mismatch on the current fetch (see Configuration).

## Operation
- States: RUN (reset state) and LOAD.
- **RUN, fetch**
  - fetch_req=1, stall=0: the next cycle gives instr=mem[fetch_addr] and instr_valid=1.
  - If fetch_addr >= DEPTH: instr=NOP_WORD, instr_valid=1, addr_err=1.
  - fetch_req=0, stall=0: instr_valid<=0; instr holds its last value.
  - stall=1: instr, instr_valid and addr_err hold their values; fetch_req is ignored.
- **RUN -> LOAD**
  - load_start=1 moves to LOAD and sets ptr=0.
  - load_start overrides a fetch in the same cycle.
  - On entry to LOAD: instr_valid<=0 and instr<=NOP_WORD.
- **LOAD**
  - load_ready=1; the handshake is load_valid && load_ready.
  - Each accepted word: mem[ptr]<=load_data, then ptr++.
  - Exit to RUN on an accepted word with load_last=1 or with ptr==DEPTH-1. load_done pulses the cycle after that word is accepted.
  - load_start in LOAD: ptr returns to 0 and the state stays LOAD. A simultaneous load_valid word is written to address 0.
  - fetch_req and stall are ignored; instr_valid stays 0.
- Reset mid-load: the block returns to RUN with ptr=0. Words already written are kept. No load_done pulse is produced.
- Memory contents are not cleared by reset; they are initialised from the elaboration-time image.

## Timing
- Reset values: instr=NOP_WORD, instr_valid=0, addr_err=0, load_ready=0, load_done=0, parity_err=0, state=RUN, ptr=0.
- Fetch latency: 1 cycle, registered output. Back-to-back fetches give 1 instruction/cycle.
- Load throughput: 1 word/cycle. load_ready rises the cycle after load_start and falls the cycle after the final word.
- A write and a fetch cannot coincide because fetch is disabled in LOAD. There is therefore no read-during-write case.
- The first fetch is accepted in the cycle in which load_done is high.

## Configuration
- IMEM_PARITY_EN defined:
  - The array stores INSTR_W+1 bits: even parity is computed on write and stored per word.
  - On each fetch the stored parity is checked. parity_err is registered alongside instr/instr_valid, obeys stall, and is 0 for out-of-range fetches.
- IMEM_PARITY_EN undefined:
  - The array is INSTR_W bits wide.
  - parity_err is tied to 0.

## Structure
- Package imem_pkg:
  - imem_state_e {RUN, LOAD}.
  - Default NOP constant.
  - Function even_parity(word).
- Sub-module imem_array: storage with one synchronous write port and one registered read port, width INSTR_W or INSTR_W+1.
- The top level holds the FSM, ptr, range check, stall hold and output registers.

## Test plan
- Reset with the default image: mem[0]=9'h10F, mem[1]=9'h1AB. Fetch addr 0 then addr 1 -> instr 9'h10F then 9'h1AB on consecutive cycles, each with instr_valid=1.
- Assert reset mid-fetch -> instr=0 and instr_valid=0 immediately (asynchronous), before the next clock edge.
- Fetch addr 1 with stall=1 for 3 cycles -> instr holds 9'h1AB with instr_valid=1. A fetch of addr 0 issued during the stall is ignored.
- DEPTH=200: fetch addr 210 -> instr=NOP_WORD, instr_valid=1, addr_err pulses once.
- load_start, then 4 words 9'h001..9'h004 with load_last on the 4th -> load_done pulses once, fetches of 0..3 return 1..4. Reset after word 2 of a second load -> RUN, addresses 0..1 hold the new words and 2..3 hold the old ones.
- With IMEM_PARITY_EN, force a bit flip in a stored word -> parity_err=1 with that fetch. Without the macro, parity_err stays 0.
